// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the instruction-fetch front end.
package fetch_pc_unit_pkg;

    localparam int          XLEN                 = 32;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam logic [1:0]  ALIGN_MASK           = 2'b00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } fetch_state_t;

    function automatic logic is_aligned(input logic [1:0] low_bits);
        return low_bits == ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory request/response and decode-side handshake bundle.
interface fetch_pc_unit_if #(
    parameter int XLEN = fetch_pc_unit_pkg::XLEN
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_pc;
    logic [31:0]     if_instr;

    // Fetch unit side
    modport master (
        output imem_req, imem_addr, if_valid, if_pc, if_instr,
        input  imem_gnt, imem_rvalid, imem_rdata, if_ready
    );

    // Memory / decode side
    modport slave (
        input  imem_req, imem_addr, if_valid, if_pc, if_instr,
        output imem_gnt, imem_rvalid, imem_rdata, if_ready
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// PC register and single-outstanding instruction-fetch sequencer.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int              XLEN         = fetch_pc_unit_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [XLEN-1:0]  pc_current,
    input  logic [XLEN-1:0]  pc_plus4,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    output logic             misalign_exc,
    fetch_pc_unit_if.master  bus
);

    fetch_state_t    state, state_next;
    logic [XLEN-1:0] pc_next;
    logic            kill, kill_next;
    logic            halted, halted_next;
    logic            capture;
    logic            redir_ok, redir_bad;
    logic [XLEN-1:0] if_pc_q;
    logic [31:0]     if_instr_q;

    assign redir_ok  = redirect_valid &&  is_aligned(redirect_target[1:0]);
    assign redir_bad = redirect_valid && !is_aligned(redirect_target[1:0]);

    assign bus.imem_req  = (state == REQ);
    assign bus.imem_addr = pc_current;
    assign bus.if_valid  = (state == OUT);
    assign bus.if_pc     = if_pc_q;
    assign bus.if_instr  = if_instr_q;

    // State, PC and presented-instruction registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pc_current   <= RESET_VECTOR;
            kill         <= 1'b0;
            halted       <= 1'b0;
            misalign_exc <= 1'b0;
            if_pc_q      <= '0;
            if_instr_q   <= '0;
        end else begin
            state        <= state_next;
            pc_current   <= pc_next;
            kill         <= kill_next;
            halted       <= halted_next;
            misalign_exc <= redir_bad;
            if (capture) begin
                if_pc_q    <= pc_current;
                if_instr_q <= bus.imem_rdata;
            end
        end
    end

    // Next-state, next-PC and kill/halt bookkeeping
    always_comb begin
        state_next  = state;
        pc_next     = pc_current;
        kill_next   = kill;
        halted_next = halted;
        capture     = 1'b0;

        // A redirect updates the PC/halt status regardless of state;
        // the per-state logic below only decides where the FSM goes.
        if (redir_ok) begin
            pc_next     = redirect_target;
            halted_next = 1'b0;
        end else if (redir_bad) begin
            halted_next = 1'b1;
        end

        case (state)
            IDLE: begin
                if (!halted_next) state_next = REQ;
            end
            REQ: begin
                // A grant alongside any redirect leaves a stale request in flight.
                if (bus.imem_gnt) begin
                    state_next = WAIT;
                    kill_next  = redirect_valid;
                end else if (redir_bad) begin
                    state_next = IDLE;
                end
            end
            WAIT: begin
                if (bus.imem_rvalid) begin
                    if (kill || redirect_valid) begin
                        kill_next  = 1'b0;
                        state_next = halted_next ? IDLE : REQ;
                    end else begin
                        capture    = 1'b1;
                        state_next = OUT;
                    end
                end else if (redirect_valid) begin
                    kill_next = 1'b1;
                end
            end
            OUT: begin
                if (redirect_valid) begin
                    state_next = redir_ok ? REQ : IDLE;
                end else if (bus.if_ready) begin
                    pc_next    = pc_plus4;
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed cycle-table bench for fetch_pc_unit.
module tb_fetch_pc_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_current;
    logic [31:0] pc_plus4;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        misalign_exc;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_pc_unit_if #(.XLEN(32)) bus ();

    fetch_pc_unit #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc_current      (pc_current),
        .pc_plus4        (pc_plus4),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .misalign_exc    (misalign_exc),
        .bus             (bus)
    );

    // External +4 adder
    assign pc_plus4 = pc_current + 32'd4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [31:0] tgt;
        logic        gnt;
        logic        rvld;
        logic [31:0] rdata;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_ifpc;
        logic [31:0] e_instr;
        logic        e_mexc;
        logic [31:0] e_pc;
    } vec_t;

    localparam int NVEC = 48;
    vec_t vecs[NVEC];

    function automatic vec_t mk(
        input logic rv, input logic [31:0] tgt, input logic gnt, input logic rvld,
        input logic [31:0] rdata, input logic rdy,
        input logic e_req, input logic [31:0] e_addr, input logic e_vld,
        input logic [31:0] e_ifpc, input logic [31:0] e_instr, input logic e_mexc,
        input logic [31:0] e_pc);
        vec_t v;
        v.rv = rv; v.tgt = tgt; v.gnt = gnt; v.rvld = rvld; v.rdata = rdata; v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_ifpc = e_ifpc;
        v.e_instr = e_instr; v.e_mexc = e_mexc; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic e_req, input logic [31:0] e_addr,
                           input logic e_vld, input logic [31:0] e_ifpc,
                           input logic [31:0] e_instr, input logic e_mexc,
                           input logic [31:0] e_pc);
        chk("imem_req",     idx, {31'd0, bus.imem_req}, {31'd0, e_req});
        chk("imem_addr",    idx, bus.imem_addr,         e_addr);
        chk("if_valid",     idx, {31'd0, bus.if_valid}, {31'd0, e_vld});
        chk("if_pc",        idx, bus.if_pc,             e_ifpc);
        chk("if_instr",     idx, bus.if_instr,          e_instr);
        chk("misalign_exc", idx, {31'd0, misalign_exc}, {31'd0, e_mexc});
        chk("pc_current",   idx, pc_current,            e_pc);
    endtask

    task automatic drive(input logic rv, input logic [31:0] tgt, input logic gnt,
                         input logic rvld, input logic [31:0] rdata, input logic rdy);
        redirect_valid   = rv;
        redirect_target  = tgt;
        bus.imem_gnt     = gnt;
        bus.imem_rvalid  = rvld;
        bus.imem_rdata   = rdata;
        bus.if_ready     = rdy;
    endtask

    initial begin
        //                rv  tgt           gnt rvld rdata         rdy | req addr          vld ifpc          instr         mexc pc
        vecs[0]  = mk(0, 32'h0,        0, 0, 32'h0,        0,   0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0);
        vecs[1]  = mk(0, 32'h0,        1, 0, 32'h0,        0,   1, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0);
        vecs[2]  = mk(0, 32'h0,        0, 1, 32'h00000013, 0,   0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0);
        vecs[3]  = mk(0, 32'h0,        0, 0, 32'h0,        1,   0, 32'h0,        1, 32'h0,        32'h00000013, 0, 32'h0);
        vecs[4]  = mk(0, 32'h0,        1, 0, 32'h0,        0,   1, 32'h4,        0, 32'h0,        32'h00000013, 0, 32'h4);
        vecs[5]  = mk(0, 32'h0,        0, 1, 32'h00100093, 0,   0, 32'h4,        0, 32'h0,        32'h00000013, 0, 32'h4);
        vecs[6]  = mk(0, 32'h0,        0, 0, 32'h0,        1,   0, 32'h4,        1, 32'h4,        32'h00100093, 0, 32'h4);
        vecs[7]  = mk(0, 32'h0,        1, 0, 32'h0,        0,   1, 32'h8,        0, 32'h4,        32'h00100093, 0, 32'h8);
        vecs[8]  = mk(0, 32'h0,        0, 1, 32'h00200113, 0,   0, 32'h8,        0, 32'h4,        32'h00100093, 0, 32'h8);
        vecs[9]  = mk(0, 32'h0,        0, 0, 32'h0,        0,   0, 32'h8,        1, 32'h8,        32'h00200113, 0, 32'h8);
        vecs[10] = mk(0, 32'h0,        0, 0, 32'h0,        0,   0, 32'h8,        1, 32'h8,        32'h00200113, 0, 32'h8);
        vecs[11] = mk(0, 32'h0,        0, 1, 32'hBAD0BAD0, 0,   0, 32'h8,        1, 32'h8,        32'h00200113, 0, 32'h8);
        vecs[12] = mk(0, 32'h0,        0, 0, 32'h0,        0,   0, 32'h8,        1, 32'h8,        32'h00200113, 0, 32'h8);
        vecs[13] = mk(0, 32'h0,        0, 0, 32'h0,        0,   0, 32'h8,        1, 32'h8,        32'h00200113, 0, 32'h8);
        vecs[14] = mk(0, 32'h0,        0, 0, 32'h0,        1,   0, 32'h8,        1, 32'h8,        32'h00200113, 0, 32'h8);
        vecs[15] = mk(0, 32'h0,        0, 0, 32'h0,        0,   1, 32'hC,        0, 32'h8,        32'h00200113, 0, 32'hC);
        vecs[16] = mk(0, 32'h0,        1, 0, 32'h0,        0,   1, 32'hC,        0, 32'h8,        32'h00200113, 0, 32'hC);
        vecs[17] = mk(1, 32'h100,      0, 0, 32'h0,        0,   0, 32'hC,        0, 32'h8,        32'h00200113, 0, 32'hC);
        vecs[18] = mk(0, 32'h0,        0, 1, 32'hDEADBEEF, 0,   0, 32'h100,      0, 32'h8,        32'h00200113, 0, 32'h100);
        vecs[19] = mk(0, 32'h0,        1, 0, 32'h0,        0,   1, 32'h100,      0, 32'h8,        32'h00200113, 0, 32'h100);
        vecs[20] = mk(0, 32'h0,        0, 1, 32'h00500293, 0,   0, 32'h100,      0, 32'h8,        32'h00200113, 0, 32'h100);
        vecs[21] = mk(0, 32'h0,        0, 0, 32'h0,        0,   0, 32'h100,      1, 32'h100,      32'h00500293, 0, 32'h100);
        vecs[22] = mk(1, 32'h102,      0, 0, 32'h0,        0,   0, 32'h100,      1, 32'h100,      32'h00500293, 0, 32'h100);
        vecs[23] = mk(0, 32'h0,        0, 0, 32'h0,        0,   0, 32'h100,      0, 32'h100,      32'h00500293, 1, 32'h100);
        vecs[24] = mk(0, 32'h0,        0, 0, 32'h0,        0,   0, 32'h100,      0, 32'h100,      32'h00500293, 0, 32'h100);
        vecs[25] = mk(0, 32'h0,        0, 0, 32'h0,        0,   0, 32'h100,      0, 32'h100,      32'h00500293, 0, 32'h100);
        vecs[26] = mk(1, 32'h200,      0, 0, 32'h0,        0,   0, 32'h100,      0, 32'h100,      32'h00500293, 0, 32'h100);
        vecs[27] = mk(0, 32'h0,        1, 0, 32'h0,        0,   1, 32'h200,      0, 32'h100,      32'h00500293, 0, 32'h200);
        vecs[28] = mk(0, 32'h0,        0, 1, 32'h00000073, 0,   0, 32'h200,      0, 32'h100,      32'h00500293, 0, 32'h200);
        vecs[29] = mk(0, 32'h0,        0, 0, 32'h0,        1,   0, 32'h200,      1, 32'h200,      32'h00000073, 0, 32'h200);
        vecs[30] = mk(0, 32'h0,        0, 0, 32'h0,        0,   1, 32'h204,      0, 32'h200,      32'h00000073, 0, 32'h204);
        vecs[31] = mk(1, 32'h300,      1, 0, 32'h0,        0,   1, 32'h204,      0, 32'h200,      32'h00000073, 0, 32'h204);
        vecs[32] = mk(0, 32'h0,        0, 1, 32'h11111111, 0,   0, 32'h300,      0, 32'h200,      32'h00000073, 0, 32'h300);
        vecs[33] = mk(1, 32'h400,      0, 0, 32'h0,        0,   1, 32'h300,      0, 32'h200,      32'h00000073, 0, 32'h300);
        vecs[34] = mk(0, 32'h0,        1, 0, 32'h0,        0,   1, 32'h400,      0, 32'h200,      32'h00000073, 0, 32'h400);
        vecs[35] = mk(0, 32'h0,        0, 1, 32'h22222222, 0,   0, 32'h400,      0, 32'h200,      32'h00000073, 0, 32'h400);
        vecs[36] = mk(1, 32'h500,      0, 0, 32'h0,        1,   0, 32'h400,      1, 32'h400,      32'h22222222, 0, 32'h400);
        vecs[37] = mk(0, 32'h0,        0, 0, 32'h0,        0,   1, 32'h500,      0, 32'h400,      32'h22222222, 0, 32'h500);
        vecs[38] = mk(1, 32'hFFFFFFFC, 0, 0, 32'h0,        0,   1, 32'h500,      0, 32'h400,      32'h22222222, 0, 32'h500);
        vecs[39] = mk(0, 32'h0,        1, 0, 32'h0,        0,   1, 32'hFFFFFFFC, 0, 32'h400,      32'h22222222, 0, 32'hFFFFFFFC);
        vecs[40] = mk(0, 32'h0,        0, 1, 32'h33333333, 0,   0, 32'hFFFFFFFC, 0, 32'h400,      32'h22222222, 0, 32'hFFFFFFFC);
        vecs[41] = mk(0, 32'h0,        0, 0, 32'h0,        1,   0, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 32'h33333333, 0, 32'hFFFFFFFC);
        vecs[42] = mk(0, 32'h0,        0, 0, 32'h0,        0,   1, 32'h0,        0, 32'hFFFFFFFC, 32'h33333333, 0, 32'h0);
        vecs[43] = mk(0, 32'h0,        1, 0, 32'h0,        0,   1, 32'h0,        0, 32'hFFFFFFFC, 32'h33333333, 0, 32'h0);
        vecs[44] = mk(1, 32'h6,        0, 0, 32'h0,        0,   0, 32'h0,        0, 32'hFFFFFFFC, 32'h33333333, 0, 32'h0);
        vecs[45] = mk(0, 32'h0,        0, 1, 32'h44444444, 0,   0, 32'h0,        0, 32'hFFFFFFFC, 32'h33333333, 1, 32'h0);
        vecs[46] = mk(0, 32'h0,        0, 0, 32'h0,        0,   0, 32'h0,        0, 32'hFFFFFFFC, 32'h33333333, 0, 32'h0);
        vecs[47] = mk(0, 32'h0,        0, 0, 32'h0,        0,   0, 32'h0,        0, 32'hFFFFFFFC, 32'h33333333, 0, 32'h0);

        // Reset state
        rst_n = 1'b0;
        drive(0, 32'h0, 0, 0, 32'h0, 0);
        repeat (2) @(negedge clk);
        #1 chk_all(-1, 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            if (i != 0) @(negedge clk);
            drive(vecs[i].rv, vecs[i].tgt, vecs[i].gnt, vecs[i].rvld, vecs[i].rdata, vecs[i].rdy);
            #1 chk_all(i, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_vld, vecs[i].e_ifpc,
                       vecs[i].e_instr, vecs[i].e_mexc, vecs[i].e_pc);
        end

        // Asynchronous reset while a fetch is outstanding; late data must be ignored
        @(negedge clk);
        drive(1, 32'h40, 0, 0, 32'h0, 0);
        #1 chk_all(100, 0, 32'h0, 0, 32'hFFFFFFFC, 32'h33333333, 0, 32'h0);
        @(negedge clk);
        drive(0, 32'h0, 1, 0, 32'h0, 0);
        #1 chk_all(101, 1, 32'h40, 0, 32'hFFFFFFFC, 32'h33333333, 0, 32'h40);
        @(negedge clk);
        drive(0, 32'h0, 0, 0, 32'h0, 0);
        #1 chk_all(102, 0, 32'h40, 0, 32'hFFFFFFFC, 32'h33333333, 0, 32'h40);
        #1 rst_n = 1'b0;
        #1 chk_all(103, 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 32'h0, 0, 1, 32'hBAD0BAD0, 0);
        #1 chk_all(104, 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0);
        @(negedge clk);
        drive(0, 32'h0, 0, 1, 32'hBAD1BAD1, 0);
        #1 chk_all(105, 1, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0);
        @(negedge clk);
        drive(0, 32'h0, 1, 0, 32'h0, 0);
        #1 chk_all(106, 1, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0);
        @(negedge clk);
        drive(0, 32'h0, 0, 1, 32'h55555555, 0);
        #1 chk_all(107, 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0);
        @(negedge clk);
        drive(0, 32'h0, 0, 0, 32'h0, 1);
        #1 chk_all(108, 0, 32'h0, 1, 32'h0, 32'h55555555, 0, 32'h0);
        @(negedge clk);
        drive(0, 32'h0, 0, 0, 32'h0, 0);
        #1 chk_all(109, 1, 32'h4, 0, 32'h0, 32'h55555555, 0, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
Program-counter register and instruction-fetch sequencer for the single-issue RISC-V core. It holds the architectural PC, drives it to the existing +4 adder stage, and takes the adder's result back as the sequential next PC. It issues one instruction-memory request at a time with a req/gnt/rvalid handshake, applies branch/jump redirects, and presents the fetched instruction to decode with a valid/ready handshake.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
XLEN, 32, address/data width; only 32 is supported.

Ports:
clk  in  1  core clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
pc_current  out  XLEN  architectural PC; feeds the +4 adder.
pc_plus4  in  XLEN  adder result, pc_current+4.
redirect_valid  in  1  branch/jump/trap redirect strobe, one cycle.
redirect_target  in  XLEN  redirect destination.
imem_req  out  1  fetch request.
imem_addr  out  XLEN  fetch address.
imem_gnt  in  1  request accepted this cycle.
imem_rvalid  in  1  read data valid; arrives at least 1 cycle after gnt.
imem_rdata  in  32  instruction word.
if_valid  out  1  instruction available to decode.
if_ready  in  1  decode accepts the instruction.
if_pc  out  XLEN  PC of the presented instruction.
if_instr  out  32  presented instruction.
misalign_exc  out  1  one-cycle pulse: redirect target not word-aligned.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: pc_current=RESET_VECTOR; state=IDLE; imem_req=0; if_valid=0; if_pc=0; if_instr=0; misalign_exc=0; kill=0; halted=0.
- States:
  - IDLE: entered from reset; moves to REQ on the next edge unless halted.
  - REQ: imem_req=1, imem_addr=pc_current. Goes to WAIT when imem_gnt=1.
  - WAIT: waits for imem_rvalid. If kill=0, capture if_instr=imem_rdata and if_pc=pc_current, then go to OUT. If kill=1, drop the data, clear kill, and go to REQ (or IDLE if halted).
  - OUT: if_valid=1. When if_valid&&if_ready, set pc_current<=pc_plus4 and go to REQ.
- Latency and throughput: with zero-wait memory (gnt in the REQ cycle, rvalid one cycle later), the first if_valid comes 3 cycles after reset release. Steady state is one instruction per 3 cycles.
- Stability rule: if_pc, if_instr and if_valid stay stable while if_valid=1 and if_ready=0. No imem_req is issued in OUT.
- imem_addr may change while imem_req=1 and gnt=0, for example on a redirect. Memory samples the address only on gnt.
- Redirect, aligned (target[1:0]==0): pc_current<=target on the same edge, in any state. Per-state effect:
  - REQ without gnt: stay in REQ; the next cycle requests the target.
  - REQ with simultaneous gnt: go to WAIT with kill=1, because the old-address request is in flight.
  - WAIT: kill<=1 and stay in WAIT. If rvalid arrives in the same cycle, drop the data and go to REQ.
  - OUT: if_valid<=0 and go to REQ. If if_ready=1 in the same cycle, the handshake counts as a transfer, but the redirect overrides the pc_plus4 update.
  - IDLE with halted=1: clear halted and go to REQ.
- Redirect, misaligned: pc_current is unchanged, misalign_exc<=1 for exactly one cycle, halted<=1. No new requests are issued until an aligned redirect arrives. An in-flight response is drained (kill=1) and then the block parks in IDLE.
- Redirect and reset together: reset wins.
- Asynchronous reset mid-transaction: all state clears immediately. Any later imem_rvalid for a pre-reset request is ignored, because the block is in IDLE or REQ.
- imem_rvalid outside WAIT is ignored. Memory is required never to return unrequested data.
- pc_plus4 is used only in OUT on a transfer; the +4 adder's wrap-around at 0xFFFF_FFFC→0x0 is accepted as is.

Decomposition:
- Shared package (core_pkg): fetch state enum {IDLE, REQ, WAIT, OUT}, XLEN, default RESET_VECTOR, and the instruction-alignment mask constant 2'b00.
- No sub-module is needed. The +4 adder stays an external instance wired through pc_current/pc_plus4. The FSM and registers live in one module.

Test Plan:
1. Reset: hold rst_n=0 with RESET_VECTOR=0x0000_0000 → pc_current=0, imem_req=0, if_valid=0. After release: one IDLE cycle, then imem_req=1 with imem_addr=0x0.
2. Sequential fetch: zero-wait memory returning 0x00000013, 0x00100093, 0x00200113, with if_ready=1 → if_pc=0x0, 0x4, 0x8 with matching if_instr, one instruction per 3 cycles.
3. Backpressure: if_ready=0 for 5 cycles while if_valid=1 → if_pc/if_instr stable, imem_req=0. On if_ready=1 the next imem_addr is pc+4.
4. Redirect in WAIT to 0x100 with rvalid one cycle later → stale data never appears on if_instr, next imem_addr=0x100, next if_pc=0x100.
5. Misaligned redirect to 0x102 → misalign_exc high for exactly 1 cycle, pc_current unchanged, no imem_req. A later redirect to 0x200 resumes fetch at 0x200.
6. rst_n asserted during WAIT, with rvalid arriving 2 cycles later → outputs clear asynchronously, late data ignored, and fetch restarts at RESET_VECTOR.
